dbus_bridge: RTL and testbench
==============================

DBUS_BRIDGE -- requirements
Module: dbus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 1023, SHALL be the maximum bus cycles a transaction may wait before being aborted with an error (legal range 1..1023).
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 core_req  in  1  core data access request (load or store), sampled on clk.
REQ-005 core_we  in  1  1 = store, 0 = load.
REQ-006 core_addr  in  32  byte address from the core.
REQ-007 core_wdata  in  32  store data.
REQ-008 core_wmask  in  4  store byte enables.
REQ-009 core_rdata  out  32  load data returned to the core.
REQ-010 core_stall  out  1  holds the core's memory stage while a transaction is outstanding.
REQ-011 core_err  out  1  one-cycle bus or timeout error pulse to the core.
REQ-012 bus_req  out  1  bus request, held until granted.
REQ-013 bus_we  out  1  bus write enable.
REQ-014 bus_addr  out  32  word-aligned bus address.
REQ-015 bus_wdata  out  32  bus write data.
REQ-016 bus_be  out  4  bus byte enables.
REQ-017 bus_gnt  in  1  slave accepts the request in the current cycle.
REQ-018 bus_rvalid  in  1  slave response valid; used for both read data and write acknowledge.
REQ-019 bus_rdata  in  32  read data, valid with bus_rvalid.
REQ-020 bus_err  in  1  slave error, valid with bus_rvalid.

Function
REQ-021 The FSM SHALL have four states:
- IDLE: no transaction.
- REQ: waiting for grant.
- RESP: waiting for response.
- DONE: result presented to the core.
REQ-022 In IDLE or DONE, core_req=1 at a clock edge SHALL capture the request and enter REQ:
- bus_addr <= {core_addr[31:2],2'b00}; bus_we <= core_we; bus_wdata <= core_wdata.
- bus_be <= core_wmask if core_we, else 4'hF.
REQ-023 In IDLE or DONE with core_req=0, the FSM SHALL go to (or stay in) IDLE.
REQ-024 bus_req SHALL be 1 exactly while in REQ; bus_addr, bus_we, bus_wdata and bus_be SHALL stay constant from capture until the next capture.
REQ-025 In REQ, bus_gnt=1 with bus_rvalid=0 SHALL move to RESP.
REQ-026 In REQ, bus_gnt=1 with bus_rvalid=1 in the same cycle SHALL complete the transaction and move directly to DONE.
REQ-027 In RESP, bus_gnt SHALL be ignored; bus_rvalid=1 SHALL move to DONE.
REQ-028 On completion, for a load with bus_err=0, core_rdata <= bus_rdata; for a store, or when bus_err=1, core_rdata SHALL hold its previous value.
REQ-029 On completion, a registered error flag <= bus_err.
REQ-030 core_stall SHALL be 1 combinationally in REQ and RESP, and 0 in IDLE and DONE.
- The core therefore sees zero stall in the cycle it issues a request and one or more stall cycles afterwards.
REQ-031 core_err SHALL equal the error flag while in DONE and SHALL be 0 in every other state.
REQ-032 core_rdata SHALL hold its value until the next load completion.
REQ-033 A 10-bit wait counter SHALL clear on capture and increment on each cycle spent in REQ or RESP without completion.
REQ-034 When the counter reaches TIMEOUT and the transaction has not completed, the FSM SHALL:
- enter DONE with the error flag set to 1;
- set core_rdata to 32'h0;
- drop bus_req.
REQ-035 A bus_rvalid arriving in IDLE or DONE (stray or late response) SHALL be ignored.
REQ-036 Minimum latency SHALL be: request edge -> REQ (1 cycle stall) -> DONE, so a zero-wait slave costs exactly one core_stall cycle.

Reset
REQ-037 Asserting reset SHALL immediately force the following, regardless of clk:
- state IDLE and wait counter 0;
- bus_req, bus_we, core_stall and core_err to 0;
- bus_addr, bus_wdata and core_rdata to 32'h0;
- bus_be to 4'h0.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction without a completion pulse; a response arriving after reset is released SHALL be ignored per REQ-035.

Verification
REQ-039 Zero-wait load: core_req=1, core_we=0, addr 0x00001006, with gnt and rvalid both 1 in the first REQ cycle and rdata 0xDEADBEEF -> bus_addr 0x00001004, bus_be 0xF, core_stall=1 for exactly 1 cycle, then DONE with core_rdata 0xDEADBEEF and core_err=0.
REQ-040 Store with waits: core_we=1, wmask 0x3, wdata 0x0000A5A5, gnt after 3 cycles, rvalid 2 cycles later -> bus_be 0x3, bus_req high for 4 cycles, core_stall high for 6 cycles, core_rdata unchanged.
REQ-041 Bus error: load answered with rvalid=1, bus_err=1 -> core_err=1 for exactly one cycle in DONE, core_rdata unchanged.
REQ-042 Timeout with TIMEOUT=8: gnt never asserted -> bus_req drops after 8 stalled cycles, core_err pulses once, core_rdata=0; a later stray rvalid -> no effect.
REQ-043 Back-to-back: core_req held high in DONE -> the next request is captured at that edge with no IDLE cycle between transactions.
REQ-044 Reset mid-RESP: reset pulsed while in RESP -> all outputs at reset values immediately; the following rvalid is ignored; core_err stays 0.

Source files
------------

// File: rtl/dbus_bridge_if.sv
// Bus-side signal bundle of the data-bus bridge.
// The bridge is the master; the memory or peripheral slave answers on gnt/rvalid.
interface dbus_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/dbus_bridge.sv
// Core data-port to bus bridge with one outstanding transaction.
// Stalls the core until the slave answers, or until the wait budget runs out.
module dbus_bridge #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [31:0]   core_addr_i,
    input  logic [31:0]   core_wdata_i,
    input  logic [3:0]    core_wmask_i,
    output logic [31:0]   core_rdata_o,
    output logic          core_stall_o,
    output logic          core_err_o,
    dbus_bridge_if.master dbus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 32'd1);
    localparam logic [9:0] WAIT_MAX  = 10'(TIMEOUT);

    state_e      state_q, state_d;
    logic [9:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic        complete_s;

    // State and captured-request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= 10'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            be_q    <= be_d;
        end
    end

    // Next-state, capture, completion and timeout logic
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        be_d       = be_q;
        complete_s = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Responses seen here are stray or late and never touch state
                if (core_req_i) begin
                    state_d = S_REQ;
                    wait_d  = 10'd0;
                    addr_d  = {core_addr_i[31:2], 2'b00};
                    we_d    = core_we_i;
                    wdata_d = core_wdata_i;
                    be_d    = core_we_i ? core_wmask_i : 4'hF;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ, S_RESP: begin
                if (state_q == S_RESP) begin
                    complete_s = dbus.bus_rvalid;
                end else begin
                    complete_s = dbus.bus_gnt & dbus.bus_rvalid;
                end

                if (complete_s) begin
                    state_d = S_DONE;
                    err_d   = dbus.bus_err;
                    if (!we_q && !dbus.bus_err) begin
                        rdata_d = dbus.bus_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    wait_d  = WAIT_MAX;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    wait_d = wait_q + 10'd1;
                    if ((state_q == S_REQ) && dbus.bus_gnt) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dbus.bus_req   = (state_q == S_REQ);
    assign dbus.bus_we    = we_q;
    assign dbus.bus_addr  = addr_q;
    assign dbus.bus_wdata = wdata_q;
    assign dbus.bus_be    = be_q;

    assign core_stall_o = (state_q == S_REQ) || (state_q == S_RESP);
    assign core_err_o   = (state_q == S_DONE) && err_q;
    assign core_rdata_o = rdata_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed and randomized transactions against a cycle-count model of the bridge.
module tb_dbus_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_wmask;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        core_err;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_rdata;

    dbus_bridge_if dbus ();

    dbus_bridge #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_wmask_i (core_wmask),
        .core_rdata_o (core_rdata),
        .core_stall_o (core_stall),
        .core_err_o   (core_err),
        .dbus         (dbus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus_req"},  32'(dbus.bus_req),  32'd0);
        check({tag, "_bus_we"},   32'(dbus.bus_we),   32'd0);
        check({tag, "_bus_addr"}, dbus.bus_addr,       32'h0);
        check({tag, "_bus_wdata"},dbus.bus_wdata,      32'h0);
        check({tag, "_bus_be"},   32'(dbus.bus_be),   32'd0);
        check({tag, "_stall"},    32'(core_stall),    32'd0);
        check({tag, "_err"},      32'(core_err),      32'd0);
        check({tag, "_rdata"},    core_rdata,          32'h0);
    endtask

    // Starts at a negedge in IDLE/DONE, ends at the negedge where DONE is visible.
    // g = grant-less REQ cycles before grant; r = RESP cycles until rvalid (0 = with grant).
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input int g, input int r,
                           input logic [31:0] rd, input logic berr, input logic idle_after);
        int   k;
        int   stalls;
        int   reqs;
        int   exp_stall;
        int   exp_reqs;
        logic timeout;
        logic exp_err;
        logic [3:0] exp_be;

        exp_stall = (r == 0) ? g + 1 : g + 1 + r;
        timeout   = (exp_stall > TO);
        if (timeout) exp_stall = TO;
        exp_reqs  = (g + 1 < exp_stall) ? g + 1 : exp_stall;
        exp_err   = timeout | berr;
        exp_be    = we ? mask : 4'hF;
        if (timeout) exp_rdata = 32'h0;
        else if (!we && !berr) exp_rdata = rd;

        check("issue_stall", 32'(core_stall), 32'd0);
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wdata;
        core_wmask = mask;
        @(negedge clk);
        core_req   = 1'b0;
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = $urandom;
        core_wdata = $urandom;
        core_wmask = 4'($urandom_range(0, 15));
        check("cap_addr",  dbus.bus_addr, {addr[31:2], 2'b00});
        check("cap_be",    32'(dbus.bus_be), 32'(exp_be));
        check("cap_we",    32'(dbus.bus_we), 32'(we));
        check("cap_wdata", dbus.bus_wdata, wdata);
        check("req_err0",  32'(core_err), 32'd0);

        k = 0; stalls = 0; reqs = 0;
        while (core_stall === 1'b1 && k < 200) begin
            stalls++;
            if (dbus.bus_req === 1'b1) reqs++;
            dbus.bus_gnt    = (k == g) ? 1'b1 : ((k > g) ? 1'($urandom_range(0, 1)) : 1'b0);
            dbus.bus_rvalid = (k == g + r);
            dbus.bus_err    = dbus.bus_rvalid ? berr : 1'($urandom_range(0, 1));
            dbus.bus_rdata  = dbus.bus_rvalid ? rd : $urandom;
            @(negedge clk);
            k++;
        end
        dbus.bus_gnt    = 1'b0;
        dbus.bus_rvalid = 1'b0;
        dbus.bus_err    = 1'b0;

        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        check("req_cycles",   32'(reqs),   32'(exp_reqs));
        check("done_req",     32'(dbus.bus_req), 32'd0);
        check("done_err",     32'(core_err), 32'(exp_err));
        check("done_rdata",   core_rdata, exp_rdata);
        check("hold_addr",    dbus.bus_addr, {addr[31:2], 2'b00});
        if (idle_after) begin
            @(negedge clk);
            check("idle_err",   32'(core_err), 32'd0);
            check("idle_stall", 32'(core_stall), 32'd0);
            check("idle_rdata", core_rdata, exp_rdata);
        end
    endtask

    initial begin
        reset           = 1'b1;
        core_req        = 1'b0;
        core_we         = 1'b0;
        core_addr       = 32'h0;
        core_wdata      = 32'h0;
        core_wmask      = 4'h0;
        dbus.bus_gnt    = 1'b0;
        dbus.bus_rvalid = 1'b0;
        dbus.bus_rdata  = 32'h0;
        dbus.bus_err    = 1'b0;
        exp_rdata       = 32'h0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait load
        run_txn(1'b0, 32'h0000_1006, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        // Store with three grant waits and response two cycles later
        run_txn(1'b1, 32'h0000_2000, 32'h0000_A5A5, 4'h3, 3, 2, 32'h1234_5678, 1'b0, 1'b1);
        // Bus error on a load
        run_txn(1'b0, 32'h0000_3008, 32'h0, 4'h0, 1, 1, 32'hCAFE_F00D, 1'b1, 1'b1);
        // Grant never arrives
        run_txn(1'b0, 32'h0000_400C, 32'h0, 4'h0, 1000, 0, 32'h5555_AAAA, 1'b0, 1'b1);
        // Stray responses after the timeout
        for (int i = 0; i < 3; i++) begin
            dbus.bus_rvalid = 1'b1;
            dbus.bus_rdata  = $urandom;
            dbus.bus_err    = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stray_rdata", core_rdata, exp_rdata);
            check("stray_err",   32'(core_err), 32'd0);
            check("stray_stall", 32'(core_stall), 32'd0);
        end
        dbus.bus_rvalid = 1'b0;
        dbus.bus_err    = 1'b0;
        // Back-to-back: second request issued while the first sits in DONE
        run_txn(1'b0, 32'h0000_5010, 32'h0, 4'h0, 0, 1, 32'h0BAD_CAFE, 1'b0, 1'b0);
        run_txn(1'b1, 32'h0000_6014, 32'h8765_4321, 4'hC, 2, 0, 32'h0, 1'b0, 1'b0);
        run_txn(1'b0, 32'h0000_7018, 32'h0, 4'h0, 2, 10, 32'h0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic rwe;
            int   rg;
            int   rr;
            rwe = 1'($urandom_range(0, 1));
            rg  = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 4));
            rr  = ($urandom_range(0, 9) == 0) ? 8 : int'($urandom_range(0, 3));
            run_txn(rwe, $urandom, $urandom, 4'($urandom_range(0, 15)), rg, rr, $urandom,
                    ($urandom_range(0, 5) == 0), (i == 39) ? 1'b1 : 1'($urandom_range(0, 1)));
        end

        // Reset while waiting for a response
        core_req   = 1'b1;
        core_we    = 1'b0;
        core_addr  = 32'h0000_0040;
        @(negedge clk);
        core_req     = 1'b0;
        dbus.bus_gnt = 1'b1;
        @(negedge clk);
        dbus.bus_gnt = 1'b0;
        check("resp_stall", 32'(core_stall), 32'd1);
        check("resp_req",   32'(dbus.bus_req), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        exp_rdata = 32'h0;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dbus.bus_rvalid = 1'b1;
            dbus.bus_rdata  = $urandom;
            dbus.bus_err    = 1'b1;
            @(negedge clk);
            check("post_rst_err",   32'(core_err), 32'd0);
            check("post_rst_rdata", core_rdata, 32'h0);
            check("post_rst_stall", 32'(core_stall), 32'd0);
            check("post_rst_req",   32'(dbus.bus_req), 32'd0);
        end
        dbus.bus_rvalid = 1'b0;
        dbus.bus_err    = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
